window_sequencer: RTL and testbench

WINDOW_SEQUENCER -- requirements
Module: window_sequencer

---
 rtl/kernel_pkg.sv | 25 ++
 rtl/line_buffer.sv | 28 ++
 rtl/window_sequencer.sv | 161 ++++++++++++++++
 tb/tb_window_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// Shared constants, kernel mode encodings and FSM state type for the window sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kernel_pkg;

    localparam int PIX_W = 24;

    localparam logic [3:0] MODE_BLUR  = 4'b0100;
    localparam logic [3:0] MODE_SOBEL = 4'b0101;
    localparam logic [3:0] MODE_PASS  = 4'b0110;
    localparam logic [3:0] MODE_VEDGE = 4'b0111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // All four legal kernel modes share the 4'b01xx prefix.
    function automatic logic is_kernel_mode(input logic [3:0] mode);
        return mode[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: synchronous RAM, registered read, read-before-write on address collision.
// Latency: read data appears one clock after rd_addr is presented.
// Backpressure: none; caller gates writes with we and holds rd_addr to hold rd_data.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr/rd_data registered read port.
module line_buffer
    import kernel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_sequencer.sv
// Raster pixel stream to 3x3 window sequencer with per-frame kernel mode latch.
// Latency: win_valid/win_flat one clock after the pixel completing the window is accepted.
// Backpressure: none; pix_valid=0 stalls all counters, buffers and window registers.
// Ports: clk, n_rst; sw, pix_in, pix_valid, sof in; win_flat, win_valid, kernel_sw, frame_done, busy out.
module window_sequencer
    import kernel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       sw,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [215:0]     win_flat,
    output logic             win_valid,
    output logic [3:0]       kernel_sw,
    output logic             frame_done,
    output logic             busy
);

    localparam int          AW     = $clog2(IMG_W);
    localparam logic [11:0] X_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_H - 1);

    state_t           state;
    logic [11:0]      x;
    logic [11:0]      y;
    logic [11:0]      x_nxt;
    logic             start;
    logic             run_acc;
    logic             accept;
    logic             eol;
    logic             last_pix;
    logic             win_hit;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] nc [3];
    logic [PIX_W-1:0] c1 [3];
    logic [PIX_W-1:0] c2 [3];
    logic [215:0]     win_nxt;

    // A sof pixel restarts from any state; plain pixels only count inside a frame.
    assign start    = pix_valid & sof;
    assign run_acc  = pix_valid & ~sof & ((state == ST_FILL) | (state == ST_RUN));
    assign accept   = start | run_acc;
    assign eol      = (x == X_LAST);
    assign last_pix = run_acc & (state == ST_RUN) & eol & (y == Y_LAST);
    assign win_hit  = run_acc & (x >= 12'd2) & (y >= 12'd2);
    assign busy     = (state != ST_IDLE);

    // Column the next accepted pixel will land on; also the line-buffer read
    // address, so the registered read data for that column is waiting when the
    // pixel arrives. While stalled this stays at x and the read data holds.
    always_comb begin
        x_nxt = x;
        if (start) begin
            x_nxt = 12'd1;
        end else if (run_acc) begin
            x_nxt = eol ? 12'd0 : x + 12'd1;
        end
    end

    // The sof pixel is column 0 even when it aborts a frame mid-line.
    assign wr_addr = start ? '0 : x[AW-1:0];

    // lb0 holds row y-1; its old contents shift into lb1 to become row y-2.
    line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (wr_addr),
        .wr_data (pix_in),
        .rd_addr (x_nxt[AW-1:0]),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (wr_addr),
        .wr_data (lb0_rd),
        .rd_addr (x_nxt[AW-1:0]),
        .rd_data (lb1_rd)
    );

    // Incoming right column, top to bottom.
    assign nc[0] = lb1_rd;
    assign nc[1] = lb0_rd;
    assign nc[2] = pix_in;

    // Row-major: index 3*r + c, c=0 oldest column, c=2 the incoming one.
    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[(3*r)*PIX_W   +: PIX_W] = c1[r];
            win_nxt[(3*r+1)*PIX_W +: PIX_W] = c2[r];
            win_nxt[(3*r+2)*PIX_W +: PIX_W] = nc[r];
        end
    end

    // c1/c2 track the two most recent columns; win_flat only updates on a
    // complete window so it holds its value between valid pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < 3; r++) begin
                c1[r] <= '0;
                c2[r] <= '0;
            end
            win_flat <= '0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    c1[r] <= c2[r];
                    c2[r] <= nc[r];
                end
            end
            if (win_hit) begin
                win_flat <= win_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            kernel_sw  <= MODE_PASS;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_hit;
            frame_done <= last_pix;
            x          <= x_nxt;
            if (start) begin
                state <= ST_FILL;
                y     <= '0;
                if (is_kernel_mode(sw)) begin
                    kernel_sw <= sw;
                end
            end else if (run_acc) begin
                if (eol) begin
                    y <= last_pix ? 12'd0 : y + 12'd1;
                end
                // Two full lines are buffered once row 1 completes.
                if ((state == ST_FILL) && eol && (y == 12'd1)) begin
                    state <= ST_RUN;
                end
                if (last_pix) begin
                    state <= ST_DONE;
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_window_sequencer.sv
module tb_window_sequencer;

    logic         clk;
    logic         n_rst;
    logic [3:0]   sw;
    logic [23:0]  pix_in;
    logic         pix_valid;
    logic         sof;
    logic [215:0] win_flat;
    logic         win_valid;
    logic [3:0]   kernel_sw;
    logic         frame_done;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [215:0] wins [$];
    logic         wdone [$];
    logic [23:0]  wpix [$];
    logic [215:0] exp_win [4];
    int           stall_hits;

    window_sequencer #(.IMG_W(4), .IMG_H(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sw         (sw),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .win_flat   (win_flat),
        .win_valid  (win_valid),
        .kernel_sw  (kernel_sw),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [215:0] pack9(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        return {24'(a8), 24'(a7), 24'(a6), 24'(a5), 24'(a4),
                24'(a3), 24'(a2), 24'(a1), 24'(a0)};
    endfunction

    // One clock of stimulus; records any window that appears after the edge.
    task automatic step(input logic v, input logic s, input logic [23:0] p);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        @(posedge clk);
        @(negedge clk);
        if (win_valid === 1'b1) begin
            wins.push_back(win_flat);
            wdone.push_back(frame_done);
            wpix.push_back(p);
        end
        if (frame_done === 1'b1) n_done++;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic clear_obs();
        wins.delete();
        wdone.delete();
        wpix.delete();
        n_done = 0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (kernel_sw !== 4'b0110) begin n_fail++; $display("FAIL reset_kernel_sw: got %b want 0110", kernel_sw); end
        n_checks++; if (win_flat !== 216'd0) begin n_fail++; $display("FAIL reset_win_flat: got %h want 0", win_flat); end
        n_rst = 1'b1;
        clear_obs();
        // Pixels without sof while idle must not start a frame.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 24'(k + 5));
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        clear_obs();
        sw = 4'b0100;
        for (int k = 0; k < 16; k++) step(1'b1, k == 0, 24'(k));
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_done: got %b want 1", busy); end
        step(1'b0, 1'b0, 24'd0);
        n_checks++; if (wins.size() != 4) begin n_fail++; $display("FAIL full_count: got %0d want 4", wins.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wins[i] !== exp_win[i]) begin
                n_fail++; $display("FAIL full_win%0d: got %h want %h", i, wins[i], exp_win[i]);
            end
        end
        n_checks++; if (wpix[0] !== 24'd10) begin n_fail++; $display("FAIL full_first_after: got %0d want 10", wpix[0]); end
        n_checks++; if (wdone[3] !== 1'b1 || n_done != 1) begin n_fail++; $display("FAIL full_frame_done: got %b/%0d want 1/1", wdone[3], n_done); end
        n_checks++; if (kernel_sw !== 4'b0100) begin n_fail++; $display("FAIL full_kernel_sw: got %b want 0100", kernel_sw); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        clear_obs();
        stall_hits = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, 24'(k));
            step(1'b0, 1'b0, 24'hABCDEF);
            if (win_valid !== 1'b0) stall_hits++;
        end
        n_checks++; if (stall_hits != 0) begin n_fail++; $display("FAIL stall_valid: got %0d want 0", stall_hits); end
        n_checks++; if (wins.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", wins.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wins[i] !== exp_win[i]) begin
                n_fail++; $display("FAIL stall_win%0d: got %h want %h", i, wins[i], exp_win[i]);
            end
        end
        n_checks++; if (wdone[3] !== 1'b1 || n_done != 1) begin n_fail++; $display("FAIL stall_frame_done: got %b/%0d want 1/1", wdone[3], n_done); end
    endtask

    task automatic test_sw_hold();
        clear_obs();
        sw = 4'b0100;
        for (int k = 0; k < 16; k++) begin
            if (k == 5) sw = 4'b0101;
            step(1'b1, k == 0, 24'(k));
            if (k == 8) begin
                n_checks++; if (kernel_sw !== 4'b0100) begin n_fail++; $display("FAIL sw_mid1: got %b want 0100", kernel_sw); end
            end
        end
        sw = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, 24'(k));
            if (k == 0) begin
                n_checks++; if (kernel_sw !== 4'b0100) begin n_fail++; $display("FAIL sw_illegal_sof: got %b want 0100", kernel_sw); end
            end
        end
        n_checks++; if (kernel_sw !== 4'b0100) begin n_fail++; $display("FAIL sw_end2: got %b want 0100", kernel_sw); end
        n_checks++; if (n_done != 2) begin n_fail++; $display("FAIL sw_done_count: got %0d want 2", n_done); end
        step(1'b0, 1'b0, 24'd0);
    endtask

    task automatic test_abort();
        clear_obs();
        sw = 4'b0100;
        for (int k = 0; k < 7; k++) step(1'b1, k == 0, 24'(k));
        // sof on the 8th pixel; the restarted frame is numbered from 0 again.
        for (int k = 0; k < 16; k++) step(1'b1, k == 0, 24'(k));
        step(1'b0, 1'b0, 24'd0);
        n_checks++; if (wins.size() != 4) begin n_fail++; $display("FAIL abort_count: got %0d want 4", wins.size()); end
        n_checks++; if (wins[0] !== exp_win[0]) begin n_fail++; $display("FAIL abort_win0: got %h want %h", wins[0], exp_win[0]); end
        n_checks++; if (wpix[0] !== 24'd10) begin n_fail++; $display("FAIL abort_first_after: got %0d want 10", wpix[0]); end
        n_checks++; if (n_done != 1 || wdone[3] !== 1'b1) begin n_fail++; $display("FAIL abort_frame_done: got %0d/%b want 1/1", n_done, wdone[3]); end
    endtask

    task automatic test_async_reset();
        clear_obs();
        sw = 4'b0101;
        for (int k = 0; k < 10; k++) step(1'b1, k == 0, 24'(k));
        n_checks++; if (kernel_sw !== 4'b0101) begin n_fail++; $display("FAIL ar_kernel_load: got %b want 0101", kernel_sw); end
        n_checks++; if (win_flat !== exp_win[3]) begin n_fail++; $display("FAIL ar_win_hold: got %h want %h", win_flat, exp_win[3]); end
        #2 n_rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", busy); end
        n_checks++; if (kernel_sw !== 4'b0110) begin n_fail++; $display("FAIL ar_kernel_sw: got %b want 0110", kernel_sw); end
        n_checks++; if (win_flat !== 216'd0) begin n_fail++; $display("FAIL ar_win_flat: got %h want 0", win_flat); end
        n_checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL ar_valid_done: got %b%b want 00", win_valid, frame_done); end
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 10; k < 16; k++) step(1'b1, 1'b0, 24'(k));
        n_checks++; if (wins.size() != 0) begin n_fail++; $display("FAIL ar_ignored_wins: got %0d want 0", wins.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_ignored_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        sw = 4'b0111;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) step(1'b1, k == 0, 24'(k));
        end
        step(1'b0, 1'b0, 24'd0);
        n_checks++; if (wins.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", wins.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wins[i + 4] !== exp_win[i]) begin
                n_fail++; $display("FAIL b2b_win%0d: got %h want %h", i + 4, wins[i + 4], exp_win[i]);
            end
        end
        n_checks++; if (n_done != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        n_checks++; if (kernel_sw !== 4'b0111) begin n_fail++; $display("FAIL b2b_kernel_sw: got %b want 0111", kernel_sw); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    initial begin
        n_rst     = 1'b0;
        sw        = 4'b0000;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        exp_win[0] = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        exp_win[1] = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        exp_win[2] = pack9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        exp_win[3] = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        test_reset();
        test_full_frame();
        test_stall();
        test_sw_hold();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
